// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryptor: one full cipher round per clock, round keys
// expanded on the fly, ciphertext presented over a valid/ready handshake.
module aes128_round_ctrl #(
  parameter bit CLEAR_ON_DONE = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_in_block,
  input  logic [127:0] i_key,
  output logic         o_ready,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_block,
  output logic [3:0]   o_round
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_e;

  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] v);
    return SBOX_FLAT[2047 - 8*int'(v) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // SubBytes and ShiftRows fused: output byte (row r, col c) comes from input column (c+r)%4.
  function automatic logic [127:0] round_xform(input logic [127:0] s, input logic last);
    logic [127:0] sr;
    logic [127:0] mc;
    sr = 128'd0;
    mc = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127 - 32*c -: 32] = mix_column(sr[127 - 32*c -: 32]);
    end
    return last ? sr : mc;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h000000};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  fsm_e         r_fsm, w_fsm_nxt;
  logic [127:0] r_state, w_state_nxt;
  logic [127:0] r_rk, w_rk_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [127:0] w_round_key;
  logic [127:0] w_round_out;

  assign w_round_key = expand_key(r_rk, rcon(r_round));
  assign w_round_out = round_xform(r_state, r_round == 4'd10) ^ w_round_key;

  assign o_ready     = (r_fsm == S_IDLE);
  assign o_out_valid = (r_fsm == S_DONE);
  assign o_out_block = (r_fsm == S_DONE) ? r_state : 128'd0;
  assign o_round     = r_round;

  // Next-state, datapath and round-counter selection.
  always_comb begin
    w_fsm_nxt   = S_IDLE;
    w_state_nxt = r_state;
    w_rk_nxt    = r_rk;
    w_round_nxt = 4'd0;
    case (r_fsm)
      S_IDLE: begin
        if (i_start) begin
          w_fsm_nxt   = S_ROUND;
          w_state_nxt = i_in_block ^ i_key;
          w_rk_nxt    = i_key;
          w_round_nxt = 4'd1;
        end else begin
          w_fsm_nxt = S_IDLE;
        end
      end
      S_ROUND: begin
        if ((r_round >= 4'd1) && (r_round <= 4'd10)) begin
          w_state_nxt = w_round_out;
          w_rk_nxt    = w_round_key;
          if (r_round == 4'd10) begin
            w_fsm_nxt   = S_DONE;
            w_round_nxt = 4'd0;
          end else begin
            w_fsm_nxt   = S_ROUND;
            w_round_nxt = r_round + 4'd1;
          end
        end else begin
          w_fsm_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_fsm_nxt = S_IDLE;
          if (CLEAR_ON_DONE) begin
            w_state_nxt = 128'd0;
            w_rk_nxt    = 128'd0;
          end else begin
            w_state_nxt = r_state;
            w_rk_nxt    = r_rk;
          end
        end else begin
          w_fsm_nxt = S_DONE;
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  // State, key and control registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm   <= S_IDLE;
      r_state <= 128'd0;
      r_rk    <= 128'd0;
      r_round <= 4'd0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_rk    <= w_rk_nxt;
      r_round <= w_round_nxt;
    end
  end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench for aes128_round_ctrl: FIPS-197 vectors, random blocks
// against a byte-level AES reference, backpressure, busy start and reset abort.
module tb_aes128_round_ctrl;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [39:0]  ROUND_SEQ = 40'hA987654321;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] in_block = 128'd0;
  logic [127:0] key = 128'd0;
  logic         out_ready = 1'b1;
  logic         ready0, valid0, ready1, valid1;
  logic [127:0] block0, block1;
  logic [3:0]   round0, round1;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sbox_m [256];

  aes128_round_ctrl #(.CLEAR_ON_DONE(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_block(in_block), .i_key(key),
    .o_ready(ready0), .o_out_valid(valid0), .i_out_ready(out_ready),
    .o_out_block(block0), .o_round(round0));

  aes128_round_ctrl #(.CLEAR_ON_DONE(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_block(in_block), .i_key(key),
    .o_ready(ready1), .o_out_valid(valid1), .i_out_ready(out_ready),
    .o_out_block(block1), .o_round(round1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return 8'((b << k) | (b >> (8 - k)));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k,
                                           output logic [127:0] last_rk);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  s [4][4];
    logic [7:0]  t [4][4];
    logic [127:0] ct;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127 - 8*(r + 4*c) -: 8] ^ w[c][31 - 8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_m[s[r][(c + r) % 4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < 10)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                      ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
        end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = s[r][c] ^ w[4*rnd + c][31 - 8*r -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ct[127 - 8*(r + 4*c) -: 8] = s[r][c];
    last_rk = {w[40], w[41], w[42], w[43]};
    return ct;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then scramble the don't-care inputs.
  task automatic launch(input logic [127:0] pt, input logic [127:0] k);
    start = 1'b1;
    in_block = pt;
    key = k;
    tick();
    start = 1'b0;
    in_block = rand128();
    key = rand128();
  endtask

  // Observe until out_valid (bounded); lat counts edges since the accept edge.
  task automatic collect(output logic [39:0] rnds, output int lat, output logic [127:0] blk);
    rnds = 40'd0;
    lat = 0;
    while (!valid0 && lat < 40) begin
      if (lat < 10) rnds[4*lat +: 4] = round0;
      tick();
      lat++;
    end
    blk = block0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_vec++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready0); end
    n_vec++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid0); end
    n_vec++; if (block0 !== 128'd0) begin n_err++; $display("FAIL reset_block: got %h want 0", block0); end
    n_vec++; if (round0 !== 4'd0) begin n_err++; $display("FAIL reset_round: got %0d want 0", round0); end
    n_vec++; if (dut0.r_state !== 128'd0 || dut0.r_rk !== 128'd0) begin
      n_err++; $display("FAIL reset_regs: state %h rk %h want 0", dut0.r_state, dut0.r_rk);
    end
  endtask

  task automatic test_fips_b();
    logic [39:0] rnds;
    int lat;
    logic [127:0] blk;
    out_ready = 1'b1;
    launch(PT_B, KEY_B);
    collect(rnds, lat, blk);
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL b_latency_edges: got %0d want 10", lat); end
    n_vec++; if (rnds !== ROUND_SEQ) begin n_err++; $display("FAIL b_round_seq: got %h want %h", rnds, ROUND_SEQ); end
    n_vec++; if (blk !== CT_B) begin n_err++; $display("FAIL b_ct: got %h want %h", blk, CT_B); end
    n_vec++; if (block1 !== CT_B) begin n_err++; $display("FAIL b_ct_clr: got %h want %h", block1, CT_B); end
    tick();
    n_vec++; if (ready0 !== 1'b1 || valid0 !== 1'b0) begin
      n_err++; $display("FAIL b_accept: ready %b valid %b want 1 0", ready0, valid0);
    end
    n_vec++; if (dut0.r_state !== CT_B || dut0.r_rk !== RK10_B) begin
      n_err++; $display("FAIL keep_regs: state %h rk %h want %h %h", dut0.r_state, dut0.r_rk, CT_B, RK10_B);
    end
    n_vec++; if (dut1.r_state !== 128'd0 || dut1.r_rk !== 128'd0) begin
      n_err++; $display("FAIL clear_regs: state %h rk %h want 0 0", dut1.r_state, dut1.r_rk);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] rnds;
    int lat;
    logic [127:0] blk;
    time t0, t1;
    out_ready = 1'b1;
    launch(PT_C, KEY_C);
    t0 = $time;
    collect(rnds, lat, blk);
    n_vec++; if (blk !== CT_C) begin n_err++; $display("FAIL c1_ct: got %h want %h", blk, CT_C); end
    tick();
    n_vec++; if (ready0 !== 1'b1 || valid0 !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: ready %b valid %b want 1 0", ready0, valid0);
    end
    launch(PT_B, KEY_B);
    t1 = $time;
    n_vec++; if (t1 - t0 !== 120) begin n_err++; $display("FAIL b2b_period: got %0t want 120", t1 - t0); end
    collect(rnds, lat, blk);
    n_vec++; if (blk !== CT_B) begin n_err++; $display("FAIL b2b_second_ct: got %h want %h", blk, CT_B); end
    tick();
  endtask

  task automatic test_random();
    logic [39:0] rnds;
    int lat;
    logic [127:0] blk, pt, k, exp_ct, exp_rk;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      pt = rand128();
      k = rand128();
      exp_ct = aes_ref(pt, k, exp_rk);
      launch(pt, k);
      collect(rnds, lat, blk);
      n_vec++; if (blk !== exp_ct) begin n_err++; $display("FAIL rand_ct[%0d]: got %h want %h", n, blk, exp_ct); end
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want 10", n, lat); end
      tick();
      n_vec++; if (dut0.r_rk !== exp_rk) begin n_err++; $display("FAIL rand_rk10[%0d]: got %h want %h", n, dut0.r_rk, exp_rk); end
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] rnds;
    int lat;
    logic [127:0] blk, pt, k, exp_ct, exp_rk;
    pt = rand128();
    k = rand128();
    exp_ct = aes_ref(pt, k, exp_rk);
    out_ready = 1'b0;
    launch(pt, k);
    collect(rnds, lat, blk);
    n_vec++; if (blk !== exp_ct) begin n_err++; $display("FAIL bp_ct: got %h want %h", blk, exp_ct); end
    for (int i = 0; i < 20; i++) begin
      start = ($urandom_range(1) == 1);
      in_block = rand128();
      key = rand128();
      n_vec++;
      if (valid0 !== 1'b1 || block0 !== exp_ct || ready0 !== 1'b0 || round0 !== 4'd0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid %b ready %b round %0d block %h want 1 0 0 %h",
                 i, valid0, ready0, round0, block0, exp_ct);
      end
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    n_vec++; if (valid0 !== 1'b1 || block0 !== exp_ct) begin
      n_err++; $display("FAIL bp_cycle21: valid %b block %h want 1 %h", valid0, block0, exp_ct);
    end
    tick();
    n_vec++; if (ready0 !== 1'b1 || valid0 !== 1'b0 || block0 !== 128'd0) begin
      n_err++; $display("FAIL bp_release: ready %b valid %b block %h want 1 0 0", ready0, valid0, block0);
    end
    tick();
    n_vec++; if (ready0 !== 1'b1 || round0 !== 4'd0) begin
      n_err++; $display("FAIL bp_no_queue: ready %b round %0d want 1 0", ready0, round0);
    end
  endtask

  task automatic test_busy_start();
    logic [39:0] rnds;
    int lat;
    logic [127:0] blk, pt, k, exp_ct, exp_rk;
    pt = rand128();
    k = rand128();
    exp_ct = aes_ref(pt, k, exp_rk);
    out_ready = 1'b1;
    launch(pt, k);
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (round0 !== 4'd5) begin n_err++; $display("FAIL busy_round: got %0d want 5", round0); end
    start = 1'b1;
    in_block = ~pt;
    key = rand128();
    tick();
    start = 1'b0;
    collect(rnds, lat, blk);
    n_vec++; if (blk !== exp_ct) begin n_err++; $display("FAIL busy_ct: got %h want %h", blk, exp_ct); end
    tick();
    n_vec++; if (ready0 !== 1'b1 || round0 !== 4'd0) begin
      n_err++; $display("FAIL busy_no_queue: ready %b round %0d want 1 0", ready0, round0);
    end
  endtask

  task automatic test_reset_mid();
    logic [39:0] rnds;
    int lat;
    logic [127:0] blk;
    out_ready = 1'b1;
    launch(rand128(), rand128());
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (round0 !== 4'd6) begin n_err++; $display("FAIL rstmid_round6: got %0d want 6", round0); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (ready0 !== 1'b1 || valid0 !== 1'b0 || round0 !== 4'd0 || block0 !== 128'd0) begin
      n_err++; $display("FAIL rstmid_abort: ready %b valid %b round %0d block %h want 1 0 0 0",
                        ready0, valid0, round0, block0);
    end
    launch(PT_B, KEY_B);
    collect(rnds, lat, blk);
    n_vec++; if (blk !== CT_B) begin n_err++; $display("FAIL rstmid_rerun: got %h want %h", blk, CT_B); end
    tick();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_b();
    test_back_to_back();
    test_random();
    test_backpressure();
    test_busy_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes128_round_ctrl.md
# aes128_round_ctrl

Iterative AES-128 encryption controller: it sequences one full cipher round per clock through the existing SubBytes/ShiftRows/mix-columns datapath. It expands the round keys on the fly and presents the ciphertext over a valid/ready handshake. It sits between the accelerator's host-side block buffer and the output FIFO, and it owns the only state and round-key registers in the encrypt path.

## Interface
- CLEAR_ON_DONE, 1, when 1 the state and round-key registers are zeroed on the DONE→IDLE transition; when 0 they hold their last values.
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to encrypt; accepted only on a cycle where ready=1.
- in_block  in  128  plaintext, sampled on the accept cycle.
- key  in  128  cipher key, sampled on the accept cycle.
- ready  out  1  high only in IDLE.
- out_valid  out  1  ciphertext valid; held high until accepted.
- out_ready  in  1  consumer accepts out_block when out_valid=1 and out_ready=1.
- out_block  out  128  ciphertext; equals the state register in DONE, otherwise 0.
- round  out  4  current round number (0 in IDLE/DONE, 1–10 in ROUND).

## Operation
- Byte order follows FIPS-197: state byte 0 = bits [127:120], byte 15 = bits [7:0]; column c = bits [127-32c -: 32].
- State machine with three states:
  - IDLE: ready=1. On start: state_reg ← in_block ^ key, rk_reg ← key, round ← 1, go to ROUND.
  - ROUND: next_rk = expand(rk_reg, rcon[round]), where expand is RotWord/SubWord/Rcon on word 3, then the XOR chain w0..w3.
    - Rounds 1–9: state_reg ← MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_rk.
    - Round 10: MixColumns is bypassed.
    - Each round: rk_reg ← next_rk, round ← round+1. After round 10, go to DONE and set round to 0.
  - DONE: out_valid=1, out_block=state_reg. On out_ready, go to IDLE and apply CLEAR_ON_DONE.
- rcon sequence for rounds 1–10: 01 02 04 08 10 20 40 80 1b 36, from a combinational lookup indexed by round.
- The round counter never leaves 1–10 in ROUND. Any illegal encoding of the state or round register returns to IDLE.
- start while not in IDLE is ignored and never queued. in_block and key are don't-care outside the accept cycle.
- out_block is forced to 0 outside DONE so that intermediate state is not exposed.

## Timing
- Reset values: ready=1, out_valid=0, out_block=0, round=0, state_reg=0, rk_reg=0, FSM=IDLE.
- rst has priority over every other input. Asserting rst mid-ROUND or in DONE aborts the operation on the next edge with no output.
- Latency: start is accepted at edge T. round shows 1..10 during cycles T+1..T+10. out_valid rises after edge T+10 and is first visible in cycle T+11.
- Throughput: a back-to-back consumer (out_ready tied high) gives one block per 12 cycles, because DONE lasts at least one cycle and IDLE at least one cycle.
- Accept in DONE happens at edge D. ready=1 and out_valid=0 in the following cycle. A start in that IDLE cycle is accepted normally.
- out_ready asserted while not in DONE has no effect.
- The critical path is one round: S-box, ShiftRows wiring, mix-columns, key-schedule XOR. No internal pipelining.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_block 3925841d02dc09fbdc118597196a0b32. out_valid must first be high exactly 11 cycles after the accept edge, and round must step 1..10.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. Then issue the App. B vector on the first cycle ready returns; both results must be correct and in order.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid and out_block stable; ready=0; start pulses ignored; accept at cycle 21 -> IDLE on the next cycle.
- Busy start: pulse start with a different plaintext at round 5 -> ignored; the first block's ciphertext is unchanged.
- Reset mid-operation: assert rst at round 6 -> next cycle ready=1, out_valid=0, round=0, out_block=0. A following App. B run gives the correct result.
- CLEAR_ON_DONE=1: after acceptance, state_reg and rk_reg read 0 via hierarchical probe. With CLEAR_ON_DONE=0, they retain the ciphertext and round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6.
